// File: rtl/rtc_wr_cdc_sync_if.sv
// rtl/rtc_wr_cdc_sync_if.sv - pclk-side write request bus of the RTC write synchronizer
interface rtc_wr_cdc_sync_if #(
  parameter int DW = 32
);
  logic          wr_en;
  logic          wr_sel;
  logic [DW-1:0] wr_data;
  logic          wr_busy;
  logic          wr_done;
  logic          wr_err;

  modport master (
    output wr_en, wr_sel, wr_data,
    input  wr_busy, wr_done, wr_err
  );

  modport slave (
    input  wr_en, wr_sel, wr_data,
    output wr_busy, wr_done, wr_err
  );
endinterface

// File: rtl/rtc_wr_cdc_sync.sv
// rtl/rtc_wr_cdc_sync.sv - toggle req/ack transfer of APB writes into the rtc_clk domain
module rtc_wr_cdc_sync #(
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 2   // 2..3
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    rtc_clk,
  input  logic                    rtc_rstn,
  rtc_wr_cdc_sync_if.slave        wr_if,
  output logic                    rtc_ld_vld,
  output logic                    rtc_ld_sel,
  output logic [DW-1:0]           rtc_ld_data
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  // pclk domain
  state_t                 state, state_nxt;
  logic [DW-1:0]          hold_data, hold_data_nxt;
  logic [DW-1:0]          pend_data, pend_data_nxt;
  logic                   hold_sel, hold_sel_nxt;
  logic                   pend_sel, pend_sel_nxt;
  logic                   pend_vld, pend_vld_nxt;
  logic                   req_tgl, req_tgl_nxt;
  logic                   err_q, err_nxt;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_last;
  logic                   ack_ed;
  logic                   done_q;

  // rtc_clk domain
  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_last;
  logic                   req_ed;
  logic                   ack_tgl;

  assign ack_ed = ack_sync[SYNC_STAGES-1] ^ ack_last;
  assign req_ed = req_sync[SYNC_STAGES-1] ^ req_last;

  assign wr_if.wr_busy = (state == WAIT) || pend_vld;
  assign wr_if.wr_done = done_q;
  assign wr_if.wr_err  = err_q;

  // Synchronize ack_tgl into pclk, detect its edge and register the done pulse
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ack_sync <= '0;
      ack_last <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_tgl};
      ack_last <= ack_sync[SYNC_STAGES-1];
      done_q   <= ack_ed;
    end
  end

  // pclk state, hold/pend buffers and request toggle
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      hold_data <= '0;
      hold_sel  <= 1'b0;
      pend_data <= '0;
      pend_sel  <= 1'b0;
      pend_vld  <= 1'b0;
      req_tgl   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_data <= hold_data_nxt;
      hold_sel  <= hold_sel_nxt;
      pend_data <= pend_data_nxt;
      pend_sel  <= pend_sel_nxt;
      pend_vld  <= pend_vld_nxt;
      req_tgl   <= req_tgl_nxt;
      err_q     <= err_nxt;
    end
  end

  // Next-state: the transfer retires on the registered done pulse so that
  // wr_busy still covers the wr_done cycle; pend is always sent before a newer write
  always_comb begin
    state_nxt     = state;
    hold_data_nxt = hold_data;
    hold_sel_nxt  = hold_sel;
    pend_data_nxt = pend_data;
    pend_sel_nxt  = pend_sel;
    pend_vld_nxt  = pend_vld;
    req_tgl_nxt   = req_tgl;
    err_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (wr_if.wr_en) begin
          hold_data_nxt = wr_if.wr_data;
          hold_sel_nxt  = wr_if.wr_sel;
          req_tgl_nxt   = ~req_tgl;
          state_nxt     = WAIT;
        end
      end
      WAIT: begin
        if (done_q) begin
          if (pend_vld) begin
            hold_data_nxt = pend_data;
            hold_sel_nxt  = pend_sel;
            req_tgl_nxt   = ~req_tgl;
            if (wr_if.wr_en) begin
              pend_data_nxt = wr_if.wr_data;
              pend_sel_nxt  = wr_if.wr_sel;
            end else begin
              pend_vld_nxt  = 1'b0;
            end
          end else if (wr_if.wr_en) begin
            hold_data_nxt = wr_if.wr_data;
            hold_sel_nxt  = wr_if.wr_sel;
            req_tgl_nxt   = ~req_tgl;
          end else begin
            state_nxt     = IDLE;
          end
        end else if (wr_if.wr_en) begin
          if (!pend_vld) begin
            pend_data_nxt = wr_if.wr_data;
            pend_sel_nxt  = wr_if.wr_sel;
            pend_vld_nxt  = 1'b1;
          end else begin
            err_nxt       = 1'b1;
          end
        end
      end
    endcase
  end

  // rtc side: synchronize req_tgl, sample the quasi-static hold word on its edge and acknowledge
  always_ff @(posedge rtc_clk or negedge rtc_rstn) begin
    if (!rtc_rstn) begin
      req_sync    <= '0;
      req_last    <= 1'b0;
      ack_tgl     <= 1'b0;
      rtc_ld_vld  <= 1'b0;
      rtc_ld_sel  <= 1'b0;
      rtc_ld_data <= '0;
    end else begin
      req_sync   <= {req_sync[SYNC_STAGES-2:0], req_tgl};
      req_last   <= req_sync[SYNC_STAGES-1];
      rtc_ld_vld <= req_ed;
      if (req_ed) begin
        rtc_ld_data <= hold_data;
        rtc_ld_sel  <= hold_sel;
        ack_tgl     <= ~ack_tgl;
      end
    end
  end

endmodule

// File: tb/tb_rtc_wr_cdc_sync.sv
// tb/tb_rtc_wr_cdc_sync.sv - self-checking bench for rtc_wr_cdc_sync
`timescale 1ns/1ps
module tb_rtc_wr_cdc_sync;
  localparam int DW = 32;

  logic          pclk;
  logic          presetn;
  logic          rtc_clk;
  logic          rtc_rstn;
  logic          rtc_ld_vld;
  logic          rtc_ld_sel;
  logic [DW-1:0] rtc_ld_data;

  realtime pclk_hp = 5.0;
  realtime rtc_hp  = 5.0;

  rtc_wr_cdc_sync_if #(.DW(DW)) wr_if ();

  rtc_wr_cdc_sync #(.DW(DW), .SYNC_STAGES(2)) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .rtc_clk     (rtc_clk),
    .rtc_rstn    (rtc_rstn),
    .wr_if       (wr_if),
    .rtc_ld_vld  (rtc_ld_vld),
    .rtc_ld_sel  (rtc_ld_sel),
    .rtc_ld_data (rtc_ld_data)
  );

  initial begin
    pclk = 1'b0;
    forever #(pclk_hp) pclk = ~pclk;
  end

  initial begin
    rtc_clk = 1'b0;
    #3;
    forever #(rtc_hp) rtc_clk = ~rtc_clk;
  end

  // Model: occupancy of the two-deep write buffer plus the queue of words still owed to rtc
  int          pass_cnt = 0;
  int          tot_cnt  = 0;
  int          occ      = 0;
  bit          err_exp  = 1'b0;
  bit          chk_en   = 1'b0;
  int          done_cnt = 0;
  int          err_cnt  = 0;
  int          ld_cnt   = 0;
  int          acc_cnt  = 0;
  logic [DW:0] exp_q[$];
  logic [DW:0] log_q[$];
  logic [DW:0] rtc_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
  endtask

  // pclk-side compare: busy, err and done against buffer occupancy
  always @(negedge pclk) begin
    if (chk_en && presetn) begin
      chk("wr_busy", wr_if.wr_busy, (occ > 0));
      chk("wr_err", wr_if.wr_err, err_exp);
      if (wr_if.wr_err) err_cnt++;
      if (wr_if.wr_done) begin
        chk("done_outstanding", (occ > 0), 1'b1);
        if (occ > 0) occ--;
        done_cnt++;
      end
      err_exp = 1'b0;
      if (wr_if.wr_en) begin
        if (occ < 2) begin
          exp_q.push_back({wr_if.wr_sel, wr_if.wr_data});
          occ++;
          acc_cnt++;
        end else begin
          err_exp = 1'b1;
        end
      end
    end
  end

  // rtc-side compare: each load must be the oldest accepted write
  always @(negedge rtc_clk) begin
    if (chk_en && rtc_rstn && rtc_ld_vld) begin
      ld_cnt++;
      log_q.push_back({rtc_ld_sel, rtc_ld_data});
      chk("ld_expected", (exp_q.size() > 0), 1'b1);
      if (exp_q.size() > 0) begin
        rtc_exp = exp_q.pop_front();
        chk("ld_sel", rtc_ld_sel, rtc_exp[DW]);
        chk("ld_data", rtc_ld_data, rtc_exp[DW-1:0]);
      end
    end
  end

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while ((occ != 0 || exp_q.size() != 0) && n < max_cyc) begin
      @(posedge pclk); #1;
      n++;
    end
    if (occ != 0 || exp_q.size() != 0) begin
      tot_cnt++;
      $display("FAIL idle_timeout: occ=%0d queued=%0d after %0d cycles, required 0/0", occ, exp_q.size(), n);
    end
    repeat (4) @(posedge pclk);
    #1;
  endtask

  task automatic write1(input logic s, input logic [DW-1:0] d);
    wr_if.wr_en   = 1'b1;
    wr_if.wr_sel  = s;
    wr_if.wr_data = d;
    @(posedge pclk); #1;
    wr_if.wr_en   = 1'b0;
  endtask

  task automatic rand_batch(input int nw, input int max_gap);
    int gap;
    for (int i = 0; i < nw; i++) begin
      write1(1'($urandom), $urandom);
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, max_gap) : $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(posedge pclk); #1;
      end
    end
  endtask

  initial begin
    int n;
    int d0;
    int e0;
    bit hit;

    presetn       = 1'b0;
    rtc_rstn      = 1'b0;
    wr_if.wr_en   = 1'b0;
    wr_if.wr_sel  = 1'b0;
    wr_if.wr_data = '0;
    repeat (4) @(posedge pclk);
    #1;
    chk("rst_busy", wr_if.wr_busy, 0);
    chk("rst_done", wr_if.wr_done, 0);
    chk("rst_err", wr_if.wr_err, 0);
    chk("rst_ld_vld", rtc_ld_vld, 0);
    chk("rst_ld_sel", rtc_ld_sel, 0);
    chk("rst_ld_data", rtc_ld_data, 0);
    presetn  = 1'b1;
    rtc_rstn = 1'b1;
    @(posedge pclk); #1;
    chk_en = 1'b1;

    // Single write with latency pinned in the 1:1 phase-offset setup
    log_q.delete();
    d0 = done_cnt;
    write1(1'b0, 32'h1234_5678);
    n = 0;
    while (!rtc_ld_vld && n < 20) begin
      @(posedge rtc_clk); #1;
      n++;
    end
    chk("t1_ld_latency", n, 3);
    chk("t1_ld_data", rtc_ld_data, 32'h1234_5678);
    chk("t1_ld_sel", rtc_ld_sel, 0);
    n = 0;
    while (!wr_if.wr_done && n < 20) begin
      @(posedge pclk); #1;
      n++;
    end
    chk("t1_done_latency", n, 3);
    @(posedge pclk); #1;
    wait_idle(200);
    chk("t1_done_cnt", done_cnt - d0, 1);
    chk("t1_ld_cnt", log_q.size(), 1);

    // Back-to-back writes one pclk apart
    log_q.delete();
    d0 = done_cnt;
    e0 = err_cnt;
    write1(1'b1, 32'hA5A5_0001);
    write1(1'b0, 32'h0000_00FF);
    wait_idle(400);
    chk("t2_ld_cnt", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t2_first", log_q[0], {1'b1, 32'hA5A5_0001});
      chk("t2_second", log_q[1], {1'b0, 32'h0000_00FF});
    end
    chk("t2_done_cnt", done_cnt - d0, 2);
    chk("t2_err_cnt", err_cnt - e0, 0);

    // Three writes while busy: third is dropped
    log_q.delete();
    d0 = done_cnt;
    e0 = err_cnt;
    write1(1'b0, 32'd1);
    write1(1'b0, 32'd2);
    write1(1'b0, 32'd3);
    wait_idle(400);
    chk("t3_ld_cnt", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t3_first", log_q[0], {1'b0, 32'd1});
      chk("t3_second", log_q[1], {1'b0, 32'd2});
    end
    chk("t3_err_cnt", err_cnt - e0, 1);
    chk("t3_done_cnt", done_cnt - d0, 2);

    // Write coincident with the first done while pend is full
    log_q.delete();
    e0 = err_cnt;
    write1(1'b0, 32'h0000_0011);
    write1(1'b1, 32'h0000_0022);
    hit = 1'b0;
    n = 0;
    while (!hit && n < 200) begin
      if (wr_if.wr_done) hit = 1'b1;
      else begin
        @(posedge pclk); #1;
        n++;
      end
    end
    chk("t4_done_seen", hit, 1);
    write1(1'b0, 32'h0000_0033);
    wait_idle(400);
    chk("t4_ld_cnt", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("t4_hold", log_q[0], {1'b0, 32'h0000_0011});
      chk("t4_pend", log_q[1], {1'b1, 32'h0000_0022});
      chk("t4_new", log_q[2], {1'b0, 32'h0000_0033});
    end
    chk("t4_err_cnt", err_cnt - e0, 0);

    // Reset during WAIT, then a clean write after both domains are reset
    write1(1'b0, 32'hCAFE_0000);
    chk_en  = 1'b0;
    presetn = 1'b0;
    #1;
    chk("t5_busy_async", wr_if.wr_busy, 0);
    rtc_rstn = 1'b0;
    repeat (4) @(posedge pclk);
    #1;
    occ     = 0;
    err_exp = 1'b0;
    exp_q.delete();
    log_q.delete();
    acc_cnt = 0;
    ld_cnt  = 0;
    presetn  = 1'b1;
    rtc_rstn = 1'b1;
    @(posedge pclk); #1;
    chk_en = 1'b1;
    write1(1'b1, 32'hDEAD_BEEF);
    wait_idle(400);
    chk("t5_ld_cnt", log_q.size(), 1);
    if (log_q.size() == 1) chk("t5_data", log_q[0], {1'b1, 32'hDEAD_BEEF});

    // Randomized traffic across clock ratios
    rand_batch(40, 30);
    wait_idle(1000);
    rtc_hp = 1.7;
    rand_batch(40, 30);
    wait_idle(1000);
    rtc_hp = 13.3;
    rand_batch(30, 60);
    wait_idle(2000);
    pclk_hp = 10.0;
    rtc_hp  = 15259.0;
    rand_batch(3, 3);
    wait_idle(40000);
    rand_batch(3, 3);
    wait_idle(40000);

    chk("deliv_count", ld_cnt, acc_cnt);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/rtc_wr_cdc_sync.md
Name: rtc_wr_cdc_sync

Overview:
- Transfers software writes (counter load value, alarm match value) from the pclk/APB domain into the always-on RTC counter domain (rtc_clk).
- Uses a toggle req/ack handshake. Data is held quasi-static in a pclk-side register while a single control bit crosses domains.
- Write-direction counterpart of the counter read-back synchronizer. Sits between the RTC APB register file and the always-on counter core.

Parameters:
- DW, 32, width of transferred data word
- SYNC_STAGES, 2, flops per synchronizer chain (legal range 2..3)

Ports:
- pclk  in  1  APB clock
- presetn  in  1  reset, asynchronous, active-low; clock pclk
- rtc_clk  in  1  always-on RTC counter clock
- rtc_rstn  in  1  async active-low reset, rtc_clk domain
- wr_en  in  1  pclk; one-cycle write strobe
- wr_sel  in  1  pclk; 0 = counter load, 1 = match register
- wr_data  in  DW  pclk; write data
- wr_busy  out  1  pclk; transfer in flight or pending
- wr_done  out  1  pclk; one-cycle pulse when ack of a transfer returns
- wr_err  out  1  pclk; one-cycle pulse when a write is dropped (overflow)
- rtc_ld_vld  out  1  rtc_clk; one-cycle load pulse
- rtc_ld_sel  out  1  rtc_clk; registered copy of sel
- rtc_ld_data  out  DW  rtc_clk; registered copy of data

Behaviour:
- Reset values:
  - pclk side, on presetn: hold_data, pend_data, hold_sel, pend_sel, req_tgl, ack sync chain, ack_last, state = IDLE, pend_vld all 0; wr_busy = wr_done = wr_err = 0.
  - rtc side, on rtc_rstn: req sync chain, req_last, ack_tgl, rtc_ld_vld, rtc_ld_sel, rtc_ld_data all 0.
- pclk FSM:
  - IDLE: on wr_en, capture wr_data/wr_sel into hold, toggle req_tgl, go to WAIT.
  - WAIT: wr_busy = 1. ack_ed = ack_sync[last] ^ ack_last.
    - On ack_ed: pulse wr_done.
    - If pend_vld: move pend into hold, toggle req_tgl, clear pend_vld, stay in WAIT.
    - Otherwise go to IDLE.
- Write while in WAIT:
  - If !pend_vld, capture into pend and set pend_vld.
  - Else pulse wr_err; the write is dropped and pend is unchanged.
- Simultaneous wr_en and ack_ed in WAIT:
  - With pend_vld = 1: pend is promoted to hold and the new write goes into pend. No error.
  - With pend_vld = 0: the new write goes directly to hold with a req toggle, and the FSM stays in WAIT.
- wr_busy = (state == WAIT) || pend_vld. It is combinational from registers (no input-to-output path).
- rtc side:
  - req_tgl passes through a SYNC_STAGES chain. req_ed = req_sync[last] ^ req_last.
  - On req_ed: rtc_ld_data <= hold_data, rtc_ld_sel <= hold_sel, rtc_ld_vld <= 1 (one cycle), ack_tgl toggles.
  - hold_* is guaranteed stable from the req toggle until the ack is observed, so sampling it is safe.
- Latency, SYNC_STAGES = 2:
  - rtc_ld_vld asserts on the 3rd rtc_clk rising edge after the req_tgl change.
  - wr_done asserts 3 pclk edges after the ack_tgl change.
- Reset mid-transfer: either domain's reset returns its side to idle. No recovery handshake is required. Software must reset both domains together. A spurious edge after a one-sided reset yields at most one extra rtc_ld_vld or one extra wr_done; this is documented, not an error.
- Data is never corrupted; order is preserved (hold before pend).

Test Plan:
- Single write, sel=0, data 0x1234_5678 -> one rtc_ld_vld with sel=0 and data 0x12345678; wr_done one pulse; wr_busy high from the cycle after wr_en until the wr_done cycle inclusive, then 0.
- Back-to-back writes A5A5_0001 (sel 1) then 0000_00FF (sel 0) one pclk apart -> two rtc_ld_vld pulses in order with matching sel/data; two wr_done pulses; no wr_err.
- Three writes while busy (1, 2, 3) -> loads 1 and 2 only; wr_err one pulse on the third write; wr_busy clears after the 2nd wr_done.
- wr_en coincident with ack_ed, pend_vld = 1 -> order hold, pend, new delivered; no wr_err.
- Clock ratios pclk:rtc_clk of 50 MHz:32.768 kHz and 1:1 -> every write delivered exactly once with correct data.
- presetn asserted during WAIT -> wr_busy = 0 immediately. A subsequent write 0xDEADBEEF, with both domains reset, is delivered correctly.
